// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, multi-cycle MDU front-end holds, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_mdu_start_i,
  output logic             pc_en_o,
  output logic             en_if_id_o,
  output logic             flush_if_id_o,
  output logic             en_id_ex_o,
  output logic             flush_id_ex_o,
  output logic             en_ex_mem_o,
  output logic             flush_ex_mem_o,
  output logic             mdu_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             proto_err_o
);

  localparam int unsigned LatW = 4;
  localparam logic [LatW-1:0] LatInit = LatW'(MDU_LAT - 2);

  typedef enum logic [0:0] {StRun, StMduWait} state_e;

  state_e           state_q, state_d;
  logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             proto_err_q, proto_err_d;
  logic             load_use;

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read_i & (ex_rd_i != '0) &
                    ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                     (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  always_comb begin
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    proto_err_d    = proto_err_q;
    pc_en_o        = 1'b1;
    en_if_id_o     = 1'b1;
    flush_if_id_o  = 1'b0;
    en_id_ex_o     = 1'b1;
    flush_id_ex_o  = 1'b0;
    en_ex_mem_o    = 1'b1;
    flush_ex_mem_o = 1'b0;

    if (rst_i) begin
      // Every pipeline register loads its preset value while the PC holds.
      pc_en_o        = 1'b0;
      flush_if_id_o  = 1'b1;
      flush_id_ex_o  = 1'b1;
      flush_ex_mem_o = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_branch_taken_i) begin
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            if (ex_mdu_start_i) proto_err_d = 1'b1;
          end else if (ex_mdu_start_i) begin
            pc_en_o        = 1'b0;
            en_if_id_o     = 1'b0;
            en_id_ex_o     = 1'b0;
            flush_ex_mem_o = 1'b1;
            lat_cnt_d      = LatInit;
            state_d        = StMduWait;
          end else if (load_use) begin
            pc_en_o       = 1'b0;
            en_if_id_o    = 1'b0;
            flush_id_ex_o = 1'b1;
          end
        end
        StMduWait: begin
          if (ex_mdu_start_i) proto_err_d = 1'b1;
          if (lat_cnt_q != '0) begin
            pc_en_o        = 1'b0;
            en_if_id_o     = 1'b0;
            en_id_ex_o     = 1'b0;
            flush_ex_mem_o = 1'b1;
            lat_cnt_d      = lat_cnt_q - LatW'(1);
          end else begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_en_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      lat_cnt_q   <= '0;
      stall_cnt_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mdu_busy_o  = (state_q == StMduWait) & ~rst_i;
  assign stall_cnt_o = stall_cnt_q;
  assign proto_err_o = proto_err_q;

endmodule
